// File: rtl/hd_upscale_4_reader.sv
// hd_upscale_4_reader: reads a SRC_W x SRC_H RGB565 frame from the shared
// frame-buffer RAM one source line at a time into a ping-pong line buffer.
// Each pixel is replayed 4x horizontally and each line 4x vertically.
// The result is a (4*SRC_W) x (4*SRC_H) window aligned to the display
// counters, delayed by two clocks.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for the fetch trigger (H_cnt == 0 on a fetch row)
// S_FETCH | one read strobe per clock, SRC_W strobes for the source line
// S_DRAIN | waiting RAM_LAT clocks for the last datum, then line_ready
module hd_upscale_4_reader #(
    parameter int SRC_W   = 160,
    parameter int SRC_H   = 120,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int RAM_LAT = 1
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] H_cnt,
    input  logic [10:0] V_cnt,
    output logic        rd_en,
    output logic [14:0] rd_addr,
    input  logic [15:0] rd_data,
    output logic [15:0] RGB565_o,
    output logic [7:0]  GREY_o,
    output logic        de_o,
    output logic        underrun
);

    localparam int ACT_W = SRC_W * 4;
    localparam int ACT_H = SRC_H * 4;
    localparam int IW    = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int LW    = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   drain_q, drain_d;
    logic [14:0]     rd_addr_q, rd_addr_d;
    logic            line_ready_q, line_ready_d;
    logic            underrun_q, underrun_d;
    logic            sel_q, sel_d;
    logic            wbuf_q, wbuf_d;

    logic [RAM_LAT-1:0] wen_q;
    logic [IW-1:0]      widx_q [RAM_LAT];

    logic [15:0] line_buf [2][SRC_W];

    logic [15:0] pix1_q;
    logic        act1_q;

    logic [10:0] next_v;
    logic [8:0]  src_line;
    logic [14:0] base_addr;
    logic        fetch_row;
    logic        trigger;
    logic        swap;
    logic        active;
    logic [IW-1:0] rd_x;
    logic [15:0] pix1_d;
    logic [7:0]  grey_d;

    // Row classification is based on the row that follows the current one,
    // so that a line is fetched during the row before it is first shown.
    always_comb begin
        next_v    = (V_cnt == 11'(V_TOTAL - 1)) ? 11'd0 : V_cnt + 11'd1;
        src_line  = next_v[10:2];
        base_addr = 15'(SRC_W) * 15'(src_line);
        fetch_row = (next_v < 11'(ACT_H)) && (next_v[1:0] == 2'b00);
        trigger   = fetch_row && (H_cnt == 12'd0);
        swap      = fetch_row && (H_cnt == 12'(H_TOTAL - 1));
        active    = (H_cnt < 12'(ACT_W)) && (V_cnt < 11'(ACT_H));
        rd_x      = IW'(H_cnt >> 2);
    end

    // Fetch FSM state and bookkeeping registers.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            drain_q      <= '0;
            rd_addr_q    <= '0;
            line_ready_q <= 1'b0;
            underrun_q   <= 1'b0;
            sel_q        <= 1'b0;
            wbuf_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drain_q      <= drain_d;
            rd_addr_q    <= rd_addr_d;
            line_ready_q <= line_ready_d;
            underrun_q   <= underrun_d;
            sel_q        <= sel_d;
            wbuf_q       <= wbuf_d;
        end
    end

    // Next-state logic; the fetch target buffer is latched at the trigger so
    // a late swap cannot redirect a fetch that is already running.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        drain_d      = drain_q;
        rd_addr_d    = rd_addr_q;
        line_ready_d = line_ready_q;
        wbuf_d       = wbuf_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d      = S_FETCH;
                    idx_d        = '0;
                    rd_addr_d    = base_addr;
                    line_ready_d = 1'b0;
                    wbuf_d       = ~sel_q;
                end
            end
            S_FETCH: begin
                if (idx_q == IW'(SRC_W - 1)) begin
                    state_d = S_DRAIN;
                    drain_d = LW'(RAM_LAT - 1);
                end else begin
                    idx_d     = idx_q + 1'b1;
                    rd_addr_d = rd_addr_q + 15'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d      = S_IDLE;
                    line_ready_d = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        underrun_d = underrun_q
                   | (trigger && (state_q != S_IDLE))
                   | (swap && !line_ready_q);
        sel_d = swap ? ~sel_q : sel_q;
    end

    assign rd_en    = (state_q == S_FETCH);
    assign rd_addr  = rd_addr_q;
    assign underrun = underrun_q;

    // Delay the strobe and index by the RAM latency to form the write port.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wen_q <= '0;
            for (int i = 0; i < RAM_LAT; i++) widx_q[i] <= '0;
        end else begin
            wen_q[0]  <= rd_en;
            widx_q[0] <= idx_q;
            for (int i = 1; i < RAM_LAT; i++) begin
                wen_q[i]  <= wen_q[i-1];
                widx_q[i] <= widx_q[i-1];
            end
        end
    end

    // Ping-pong line buffer write; contents need no reset.
    always_ff @(posedge pclk) begin
        if (wen_q[RAM_LAT-1]) line_buf[wbuf_q][widx_q[RAM_LAT-1]] <= rd_data;
    end

    // Stage 1 read: pixel index is H_cnt/4 from the displayed buffer.
    always_comb begin
        pix1_d = active ? line_buf[sel_q][rd_x] : 16'd0;
    end

    // Stage 1 register: buffered pixel and active flag.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pix1_q <= '0;
            act1_q <= 1'b0;
        end else begin
            pix1_q <= pix1_d;
            act1_q <= active;
        end
    end

    // Grey = 2*R5 + 2*G6 + B5; peaks at 219 so 8 bits never overflow.
    always_comb begin
        grey_d = {2'b00, pix1_q[15:11], 1'b0}
               + {1'b0, pix1_q[10:5], 1'b0}
               + {3'b000, pix1_q[4:0]};
    end

    // Stage 2 register: blanked outputs outside the active window.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            RGB565_o <= '0;
            GREY_o   <= '0;
            de_o     <= 1'b0;
        end else if (act1_q) begin
            RGB565_o <= pix1_q;
            GREY_o   <= grey_d;
            de_o     <= 1'b1;
        end else begin
            RGB565_o <= '0;
            GREY_o   <= '0;
            de_o     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hd_upscale_4_reader.sv
// Bench for hd_upscale_4_reader: two instances (RAM latency 1 and 4) share
// one set of display counters; a reduced frame geometry keeps runs short.
module tb_hd_upscale_4_reader;

    localparam int SW = 16;
    localparam int SH = 12;
    localparam int HT = 80;
    localparam int VT = 52;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic [11:0] H_cnt = '0;
    logic [10:0] V_cnt = '0;

    logic        rd_en1, rd_en4, de1, de4, ur1, ur4;
    logic [14:0] addr1, addr4;
    logic [15:0] rdat1, rdat4, rgb1, rgb4;
    logic [7:0]  grey1, grey4;

    hd_upscale_4_reader #(.SRC_W(SW), .SRC_H(SH), .H_TOTAL(HT), .V_TOTAL(VT), .RAM_LAT(1)) u_dut1 (
        .pclk(pclk), .rst(rst), .H_cnt(H_cnt), .V_cnt(V_cnt),
        .rd_en(rd_en1), .rd_addr(addr1), .rd_data(rdat1),
        .RGB565_o(rgb1), .GREY_o(grey1), .de_o(de1), .underrun(ur1));

    hd_upscale_4_reader #(.SRC_W(SW), .SRC_H(SH), .H_TOTAL(HT), .V_TOTAL(VT), .RAM_LAT(4)) u_dut4 (
        .pclk(pclk), .rst(rst), .H_cnt(H_cnt), .V_cnt(V_cnt),
        .rd_en(rd_en4), .rd_addr(addr4), .rd_data(rdat4),
        .RGB565_o(rgb4), .GREY_o(grey4), .de_o(de4), .underrun(ur4));

    always #5 pclk = ~pclk;

    // Frame-buffer image: mode 0 is the {y,x} pattern, mode 1 is random.
    logic [15:0] rnd_img [SW*SH];
    int ram_mode = 0;

    function automatic logic [15:0] ram_word(input int mode, input int addr);
        logic [6:0] yy;
        logic [7:0] xx;
        if (addr < 0 || addr >= SW*SH) return 16'hDEAD;
        if (mode == 0) begin
            yy = 7'(addr / SW);
            xx = 8'(addr % SW);
            return {yy, xx};
        end
        return rnd_img[addr];
    endfunction

    function automatic int grey_of(input logic [15:0] p);
        return 2*int'(p[15:11]) + 2*int'(p[10:5]) + int'(p[4:0]);
    endfunction

    function automatic bit is_fetch_row(input int v);
        int nv;
        nv = (v == VT-1) ? 0 : v + 1;
        return (nv < SH*4) && (nv % 4 == 0);
    endfunction

    function automatic int next_line(input int v);
        return ((v == VT-1) ? 0 : v + 1) / 4;
    endfunction

    // RAM models with 1-clock and 4-clock read latency.
    logic [15:0] r1_q;
    logic [15:0] r4_q [4];
    always @(posedge pclk) begin
        r1_q    <= rd_en1 ? ram_word(ram_mode, int'(addr1)) : 16'hDEAD;
        r4_q[0] <= rd_en4 ? ram_word(ram_mode, int'(addr4)) : 16'hDEAD;
        r4_q[1] <= r4_q[0];
        r4_q[2] <= r4_q[1];
        r4_q[3] <= r4_q[2];
    end
    assign rdat1 = r1_q;
    assign rdat4 = r4_q[3];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t H=%0d V=%0d", tag, obs, exp, $time, H_cnt, V_cnt);
        end
    endtask

    // Model state: counters on the bus (cur) and one step earlier (prv),
    // each tagged with whether the displayed buffer holds known data.
    int cur_h, cur_v, prv_h, prv_v;
    bit cur_valid, prv_valid;
    int cur_mode, prv_mode;
    bit disp_valid = 0;
    int disp_mode  = 0;
    bit started    = 0;
    int skip       = 0;
    int fcnt       = -1;

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en1"}, rd_en1, 0);
        chk({tag, "_rd_en4"}, rd_en4, 0);
        chk({tag, "_de1"},  de1, 0);
        chk({tag, "_de4"},  de4, 0);
        chk({tag, "_rgb1"}, rgb1, 0);
        chk({tag, "_rgb4"}, rgb4, 0);
        chk({tag, "_grey1"}, grey1, 0);
        chk({tag, "_grey4"}, grey4, 0);
        chk({tag, "_ur1"}, ur1, 0);
        chk({tag, "_ur4"}, ur4, 0);
    endtask

    task automatic do_checks();
        bit exp_rd, act;
        int exp_addr;
        logic [15:0] p;
        if (rst) begin
            check_zero("in_reset");
            return;
        end
        exp_rd = started && is_fetch_row(cur_v) && (cur_h < SW);
        chk("rd_en1", rd_en1, exp_rd);
        chk("rd_en4", rd_en4, exp_rd);
        if (exp_rd) begin
            exp_addr = SW * next_line(cur_v) + cur_h;
            chk("rd_addr1", addr1, exp_addr);
            chk("rd_addr4", addr4, exp_addr);
        end
        chk("underrun1", ur1, 0);
        chk("underrun4", ur4, 0);
        if (skip > 0) begin
            skip--;
            return;
        end
        act = (prv_h < SW*4) && (prv_v < SH*4);
        chk("de1", de1, act);
        chk("de4", de4, act);
        if (!act) begin
            chk("blank_rgb1", rgb1, 0);
            chk("blank_grey1", grey1, 0);
            chk("blank_rgb4", rgb4, 0);
            chk("blank_grey4", grey4, 0);
        end else if (prv_valid) begin
            p = ram_word(prv_mode, SW * (prv_v / 4) + prv_h / 4);
            chk("rgb1", rgb1, p);
            chk("rgb4", rgb4, p);
            chk("grey1", grey1, grey_of(p));
            chk("grey4", grey4, grey_of(p));
            if (p == 16'hFFFF) chk("grey_white", grey1, 219);
            if (p == 16'hF800) chk("grey_red", grey1, 62);
            if (p == 16'h001F) chk("grey_blue", grey1, 31);
        end
    endtask

    task automatic drive_next();
        int nh, nv;
        prv_h = cur_h; prv_v = cur_v; prv_valid = cur_valid; prv_mode = cur_mode;
        nh = cur_h + 1;
        nv = cur_v;
        if (nh == HT) begin
            nh = 0;
            nv = (cur_v == VT-1) ? 0 : cur_v + 1;
        end
        cur_h = nh;
        cur_v = nv;
        if (nh == 0 && nv == 0) begin
            fcnt++;
            disp_mode = ram_mode;
        end
        cur_valid = disp_valid;
        cur_mode  = disp_mode;
        if (nh == 0) started = !rst && is_fetch_row(nv);
        if (nh == HT-1 && started && is_fetch_row(nv)) disp_valid = 1;
        H_cnt = 12'(nh);
        V_cnt = 11'(nv);
    endtask

    task automatic clk_step();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        int steps;
        bit rst_done;
        steps = 0;
        rst_done = 0;
        for (int i = 0; i < SW*SH; i++) rnd_img[i] = 16'($urandom);
        rnd_img[0] = 16'hFFFF;
        rnd_img[1] = 16'hF800;
        rnd_img[2] = 16'h001F;
        cur_h = 0; cur_v = 47; prv_h = 0; prv_v = 47;
        cur_valid = 0; prv_valid = 0; cur_mode = 0; prv_mode = 0;
        H_cnt = 12'(cur_h);
        V_cnt = 11'(cur_v);
        rst = 1'b1;

        // Free run: pattern frame, then random frame with a mid-fetch reset.
        while (!(fcnt == 2 && cur_v == 12)) begin
            clk_step();
            do_checks();
            if (steps == 3) begin
                rst  = 1'b0;
                skip = 1;
            end
            if (fcnt == 1 && cur_h == SW/2 && cur_v == 3 && !rst_done && !rst) begin
                rst = 1'b1;
                rst_done = 1;
                #1;
                check_zero("rst_midfetch");
                started = 0;
                disp_valid = 0;
            end else if (rst_done && rst && cur_h == 2 && cur_v == 4) begin
                rst  = 1'b0;
                skip = 1;
            end
            drive_next();
            if (fcnt == 0 && cur_v == 46 && cur_h == 0) ram_mode = 1;
            steps++;
        end

        // Swap during a fetch raises underrun, which then sticks.
        rst = 1'b1; H_cnt = 12'd10; V_cnt = 11'd0;
        clk_step();
        rst = 1'b0;
        clk_step();
        V_cnt = 11'd3; H_cnt = 12'd0;
        clk_step();
        chk("ur_fetch_go", rd_en1, 1);
        chk("ur_before_swap", ur1, 0);
        H_cnt = 12'(HT-1);
        clk_step();
        chk("ur_swap1", ur1, 1);
        chk("ur_swap4", ur4, 1);
        V_cnt = 11'd4;
        for (int h = 0; h < HT; h++) begin
            H_cnt = 12'(h);
            clk_step();
        end
        chk("ur_sticky1", ur1, 1);
        chk("ur_sticky4", ur4, 1);

        // Reset clears underrun; a repeated trigger while busy sets it.
        rst = 1'b1;
        #1;
        chk("ur_clear1", ur1, 0);
        chk("ur_clear4", ur4, 0);
        H_cnt = 12'd10; V_cnt = 11'd0;
        clk_step();
        rst = 1'b0;
        clk_step();
        V_cnt = 11'd3; H_cnt = 12'd0;
        clk_step();
        chk("ur_first_trig1", ur1, 0);
        clk_step();
        clk_step();
        H_cnt = 12'd1;
        clk_step();
        chk("ur_retrig1", ur1, 1);
        chk("ur_retrig4", ur4, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
